mips_main_ctrl: RTL and testbench

MIPS_MAIN_CTRL -- requirements
Module: mips_main_ctrl

---
 rtl/mips_main_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mips_main_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_main_ctrl.sv
// Multi-cycle MIPS main control FSM: Moore decode of the current state plus
// combinational pc_load (BRANCH) and illegal (DECODE) terms.
module mips_main_ctrl #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_en,
    output logic       pc_load,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       illegal
);

    localparam int unsigned OPC_W = 6;
    localparam int unsigned ST_W  = 4;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    state_t           state_q;
    state_t           state_d;
    state_t           state_cur;
    logic [OPC_W-1:0] opcode_q;

    // State register; opcode is captured in DECODE so MEMADR can pick lw/sw.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

    // Next state from the register; outputs decode FETCH while reset is low.
    always_comb begin
        state_d    = state_q;
        state_cur  = rst ? state_q : S_FETCH;
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        pc_source  = 2'd0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_EXEC:   state_d = S_RWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase

        case (state_cur)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                pc_en    = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
                    default:                                       illegal = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_source = 2'd1;
                pc_load   = zero;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_load   = 1'b1;
                pc_source = 2'd2;
            end
            default: ;
        endcase
    end

    assign state = state_cur;

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Scoreboard bench for mips_main_ctrl: stimulus queues expected output vectors,
// a negedge monitor pops and compares; a second queue holds per-instruction latencies.
module tb_mips_main_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;

    always #5 clk = ~clk;

    logic       d0_pc_en, d0_pc_load, d0_iord, d0_mem_read, d0_mem_write, d0_ir_write;
    logic       d0_reg_dst, d0_mem_to_reg, d0_reg_write, d0_alu_src_a, d0_illegal;
    logic [1:0] d0_pc_source, d0_alu_src_b, d0_alu_op;
    logic [3:0] d0_state;
    logic       d1_pc_en, d1_pc_load, d1_iord, d1_mem_read, d1_mem_write, d1_ir_write;
    logic       d1_reg_dst, d1_mem_to_reg, d1_reg_write, d1_alu_src_a, d1_illegal;
    logic [1:0] d1_pc_source, d1_alu_src_b, d1_alu_op;
    logic [3:0] d1_state;

    mips_main_ctrl #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .pc_en(d0_pc_en), .pc_load(d0_pc_load), .pc_source(d0_pc_source),
        .iord(d0_iord), .mem_read(d0_mem_read), .mem_write(d0_mem_write),
        .ir_write(d0_ir_write), .reg_dst(d0_reg_dst), .mem_to_reg(d0_mem_to_reg),
        .reg_write(d0_reg_write), .alu_src_a(d0_alu_src_a), .alu_src_b(d0_alu_src_b),
        .alu_op(d0_alu_op), .state(d0_state), .illegal(d0_illegal)
    );

    mips_main_ctrl #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .pc_en(d1_pc_en), .pc_load(d1_pc_load), .pc_source(d1_pc_source),
        .iord(d1_iord), .mem_read(d1_mem_read), .mem_write(d1_mem_write),
        .ir_write(d1_ir_write), .reg_dst(d1_reg_dst), .mem_to_reg(d1_mem_to_reg),
        .reg_write(d1_reg_write), .alu_src_a(d1_alu_src_a), .alu_src_b(d1_alu_src_b),
        .alu_op(d1_alu_op), .state(d1_state), .illegal(d1_illegal)
    );

    logic [20:0] vec0, vec1;
    assign vec0 = {d0_state, d0_pc_en, d0_pc_load, d0_pc_source, d0_iord, d0_mem_read,
                   d0_mem_write, d0_ir_write, d0_reg_dst, d0_mem_to_reg, d0_reg_write,
                   d0_alu_src_a, d0_alu_src_b, d0_alu_op, d0_illegal};
    assign vec1 = {d1_state, d1_pc_en, d1_pc_load, d1_pc_source, d1_iord, d1_mem_read,
                   d1_mem_write, d1_ir_write, d1_reg_dst, d1_mem_to_reg, d1_reg_write,
                   d1_alu_src_a, d1_alu_src_b, d1_alu_op, d1_illegal};

    typedef struct {
        bit          which;
        logic [20:0] exp;
        string       name;
    } sb_t;

    sb_t sb_q[$];
    int  lat_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  lat_en = 1'b0;
    int  lat_cyc = 0;

    // Control-word table for each state, written from the state descriptions.
    function automatic logic [20:0] exp_vec(input logic [3:0] s, input logic z,
                                            input logic [5:0] op);
        logic pe = 0, pl = 0, ia = 0, mr = 0, mw = 0, irw = 0;
        logic rd = 0, m2r = 0, rw = 0, asa = 0, ill = 0;
        logic [1:0] ps = 0, asb = 0, aop = 0;
        case (s)
            4'd0:  begin mr = 1; irw = 1; pe = 1; end
            4'd1:  begin
                asb = 2'd3;
                ill = !(op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02});
            end
            4'd2:  begin asa = 1; asb = 2'd2; end
            4'd3:  begin mr = 1; ia = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; ia = 1; end
            4'd6:  begin asa = 1; aop = 2'd2; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin asa = 1; aop = 2'd1; ps = 2'd1; pl = z; end
            4'd9:  begin asa = 1; asb = 2'd2; end
            4'd10: rw = 1;
            4'd11: begin pl = 1; ps = 2'd2; end
            default: ;
        endcase
        return {s, pe, pl, ps, ia, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ill};
    endfunction

    // Reference next-state model for legal opcodes.
    function automatic logic [3:0] ref_next(input logic [3:0] s, input logic [5:0] op);
        case (s)
            4'd0: return 4'd1;
            4'd1: case (op)
                6'h23, 6'h2B: return 4'd2;
                6'h00:        return 4'd6;
                6'h04:        return 4'd8;
                6'h08:        return 4'd9;
                6'h02:        return 4'd11;
                default:      return 4'd0;
            endcase
            4'd2: return (op == 6'h2B) ? 4'd5 : 4'd3;
            4'd3: return 4'd4;
            4'd6: return 4'd7;
            4'd9: return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [5:0] op);
        case (op)
            6'h23:               return 5;
            6'h2B, 6'h00, 6'h08: return 4;
            default:             return 3;
        endcase
    endfunction

    task automatic step(input logic [5:0] op, input logic z, input logic r,
                        input logic [3:0] es, input bit which, input string name);
        sb_t e;
        @(posedge clk);
        #1;
        opcode = op;
        zero   = z;
        rst    = r;
        e.which = which;
        e.exp   = exp_vec(es, z, op);
        e.name  = name;
        sb_q.push_back(e);
    endtask

    task automatic run(input logic [5:0] op, input logic z, input string name,
                       input int n, input logic [31:0] seq, input bit which);
        for (int i = 0; i < n; i++) begin
            step(op, z, 1'b1, seq[4*(n-1-i) +: 4], which, name);
        end
    endtask

    // Monitor: compare queued expectations, pc_en/pc_load exclusion, latencies.
    always @(negedge clk) begin
        sb_t         m_e;
        logic [20:0] m_act;
        int          m_lat;
        while (sb_q.size() > 0) begin
            m_e   = sb_q.pop_front();
            m_act = m_e.which ? vec1 : vec0;
            total++;
            if (m_act !== m_e.exp) begin
                bad++;
                $display("FAIL %s dut%0d: got %h want %h", m_e.name, m_e.which, m_act, m_e.exp);
            end
        end
        total++;
        if (d0_pc_en && d0_pc_load) begin
            bad++;
            $display("FAIL pc_excl: got pc_en=%b pc_load=%b want not both", d0_pc_en, d0_pc_load);
        end
        if (!lat_en) begin
            lat_cyc = 0;
        end else if (d0_state == 4'd0) begin
            if (lat_cyc > 0) begin
                m_lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
                total++;
                if (lat_cyc != m_lat) begin
                    bad++;
                    $display("FAIL latency: got %0d want %0d", lat_cyc, m_lat);
                end
            end
            lat_cyc = 1;
        end else begin
            lat_cyc = lat_cyc + 1;
        end
    end

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        logic       z;
        logic [3:0] s;
        ops[0] = 6'h23; ops[1] = 6'h2B; ops[2] = 6'h00;
        ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h02;
        rst = 1'b0; opcode = 6'h00; zero = 1'b0;

        step(6'h23, 1'b0, 1'b0, 4'd0, 1'b0, "reset0");
        step(6'h23, 1'b0, 1'b0, 4'd0, 1'b0, "reset1");
        run(6'h23, 1'b0, "lw",     5, 32'h01234, 1'b0);
        run(6'h2B, 1'b0, "sw",     4, 32'h0125,  1'b0);
        run(6'h00, 1'b0, "rtype",  4, 32'h0167,  1'b0);
        run(6'h08, 1'b0, "addi",   4, 32'h019A,  1'b0);
        run(6'h04, 1'b1, "beq_t",  3, 32'h018,   1'b0);
        run(6'h04, 1'b0, "beq_nt", 3, 32'h018,   1'b0);
        run(6'h02, 1'b0, "jump",   3, 32'h01B,   1'b0);
        run(6'h3F, 1'b0, "illegal", 2, 32'h01,   1'b0);
        step(6'h23, 1'b0, 1'b1, 4'd0, 1'b0, "illegal_back");

        // dut1 trapped on the illegal opcode; it must sit in HALT until reset.
        for (int i = 0; i < 9; i++) step(6'h23, 1'b0, 1'b1, 4'd15, 1'b1, "halt_hold");
        step(6'h23, 1'b0, 1'b0, 4'd0, 1'b1, "halt_rst");
        run(6'h23, 1'b0, "trap_lw", 5, 32'h01234, 1'b1);

        // Reset asserted mid-store while in MEMWR.
        run(6'h2B, 1'b0, "sw_part", 4, 32'h0125, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        step(6'h2B, 1'b0, 1'b0, 4'd0, 1'b0, "sw_rst");
        step(6'h2B, 1'b0, 1'b1, 4'd0, 1'b0, "sw_rst_rel");
        step(6'h2B, 1'b0, 1'b1, 4'd1, 1'b0, "sw_again");
        step(6'h2B, 1'b0, 1'b1, 4'd2, 1'b0, "sw_again");
        step(6'h2B, 1'b0, 1'b1, 4'd5, 1'b0, "sw_again");

        @(negedge clk);
        #1 lat_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            op = ops[$urandom_range(0, 5)];
            z  = 1'($urandom_range(0, 1));
            lat_q.push_back(lat_of(op));
            s = 4'd0;
            do begin
                step(op, z, 1'b1, s, 1'b0, "rand");
                s = ref_next(s, op);
            end while (s != 4'd0);
        end
        step(6'h00, 1'b0, 1'b1, 4'd0, 1'b0, "rand_end");
        @(negedge clk);
        #1 lat_en = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0 || lat_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got sb=%0d lat=%0d left want 0", sb_q.size(), lat_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
